uart_rx_ovs: RTL and testbench
==============================

// Module: uart_rx_ovs
// PURPOSE
// Next-gen UART RX. Oversampled (OVS ticks/bit) with 3-sample majority vote, false-start rejection,
// runtime-configurable frame (5..MAX_DATA data bits, parity none/even/odd, 1/2 stop), per-frame
// parity/framing/break status, and a one-entry valid/ready output holding register with sticky overrun.
// Sits between the pad synchroniser and the RX FIFO / AXI-lite register bank, in the fixed clk_i domain.
// PARAMETERS
// DIV_SIZE     16  width of baud_div_i (clk_i cycles per oversample tick)
// MAX_DATA     9   max data bits per frame; also the width of rx_data_o
// OVS          16  oversample ticks per bit; even, >=4
// SYNC_STAGES  3   rx_i synchroniser depth, >=2
// PORTS
// clk_i         in   1         clock
// rstn_i        in   1         reset, asynchronous, active-low
// en_i          in   1         receiver enable
// baud_div_i    in   DIV_SIZE  clk_i cycles per oversample tick; 0 treated as 1
// data_bits_i   in   4         data bits per frame, 5..MAX_DATA; values outside clamp to that range
// parity_en_i   in   1         parity bit present
// parity_odd_i  in   1         0=even, 1=odd parity
// stop_bits_i   in   1         0=1 stop bit, 1=2 stop bits
// rx_i          in   1         serial input (async)
// rx_data_o     out  MAX_DATA  received data, LSB-aligned, unused MSBs zero
// rx_valid_o    out  1         output register holds an unread frame
// rx_ready_i    in   1         consumer accepts (transfer = rx_valid_o & rx_ready_i)
// parity_err_o  out  1         parity mismatch for frame in rx_data_o
// frame_err_o   out  1         a stop bit sampled 0 for frame in rx_data_o
// break_o       out  1         1-cycle pulse: break condition detected
// overrun_o     out  1         sticky: completed frame dropped because output register was full
// err_clr_i     in   1         clears overrun_o
// BEHAVIOUR
// - Reset: all outputs 0; synchroniser flops reset to 1; FSM in IDLE.
// - Tick gen: counter 0..max(baud_div_i,1)-1, tick on terminal count; free-running, restarts at start detect.
// - ovs_cnt counts ticks 0..OVS-1 per bit. Samples at OVS/2-1, OVS/2, OVS/2+1; bit value = majority.
// - Config (data_bits, parity_en/odd, stop_bits) latched at start detect; changes mid-frame ignored.
// - FSM: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
//   IDLE: en_i & synced rx==0 -> START, tick counter and ovs_cnt cleared.
//   START: at vote point, majority 1 -> IDLE (false start, no status); else -> DATA at ovs_cnt==OVS-1.
//   DATA: LSB first, one bit per bit period; after N bits -> PARITY if enabled else STOP1.
//   PARITY: err = ^data ^ pbit ^ parity_odd (nonzero = error) -> STOP1.
//   STOP1: at vote point: if stop_bits==1 -> STOP2 (at bit end) else frame complete.
//   STOP2: at vote point frame complete. frame_err if any stop bit voted 0.
// - Frame completes at the final stop bit's last vote sample (no wait for bit end, allows resync);
//   rx_valid_o rises the next clk_i.
// - Break: all data bits, parity (if any) and first stop bit voted 0 -> break_o pulse, frame loaded
//   with frame_err_o=1, FSM -> BRK_WAIT until synced rx==1, then IDLE.
// - Output reg: load on completion if !rx_valid_o or transfer this cycle (valid stays 1); else keep old
//   data/status, drop new frame, set overrun_o. Transfer without new frame clears rx_valid_o.
// - overrun_o: set has priority over err_clr_i in the same cycle.
// - en_i low while not IDLE: abort to IDLE next cycle, partial frame discarded, output reg untouched.
// - Counters/arith: ovs_cnt $clog2(OVS) bits, bit count 4 bits; compares use >= for baud_div_i changes.
// STRUCTURE
// - uart_pkg: FSM state localparams, OVS default, data_bits min/max constants, status bit indices.
// - Sub-module uart_rx_ovs_tick: baud divider (clear input, tick output); FSM + output reg in top.
// TESTING (baud_div_i=4, OVS=16 -> 64 clk/bit)
// - 8N1 send 0xA5 -> rx_data_o=0x0A5, rx_valid_o=1 ~9.5 bit times after start edge, no error flags.
// - 7E1 send 0x41 with parity bit 1 -> rx_data_o=0x041, parity_err_o=1; 0x41 with pbit 0 -> no error.
// - rx_i low 20 clk then high -> no frame, FSM back in IDLE, rx_valid_o stays 0.
// - 8N2 0x55, second stop bit 0 -> frame_err_o=1; 8N1 rx held low 2 frames -> break_o pulse once,
//   no new frame until rx high.
// - Two frames 0x11, 0x22 with rx_ready_i=0 -> rx_data_o=0x011, overrun_o=1; err_clr_i -> overrun_o=0;
//   rx_ready_i=1 on completion cycle -> 0x22 loaded, no overrun.
// - en_i low during DATA, then new 0x3C frame -> only 0x3C delivered; rstn_i low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared FSM encoding, frame-config struct and constants for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_e;

  localparam int OVS_DEFAULT   = 16;
  localparam int DATA_BITS_MIN = 5;

  // Bit positions inside the per-frame status vector.
  localparam int STAT_PAR = 0;
  localparam int STAT_FRM = 1;
  localparam int STAT_W   = 2;

  typedef struct packed {
    logic [3:0] nbits;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } rx_cfg_t;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int max_bits);
    logic [3:0] r;
    if (int'(req) < DATA_BITS_MIN) r = 4'(DATA_BITS_MIN);
    else if (int'(req) > max_bits) r = 4'(max_bits);
    else r = req;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_ovs_tick.sv
// Oversample tick generator: one-cycle tick every max(baud_div_i,1) cycles, restarted by clr_i.
// Tick is combinational from the count register; no backpressure.
module uart_rx_ovs_tick #(
  parameter int DIV_SIZE = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                clr_i,
  input  logic [DIV_SIZE-1:0] baud_div_i,
  output logic                tick_o
);

  logic [DIV_SIZE-1:0] cnt_q, cnt_d;
  logic [DIV_SIZE-1:0] div_last;
  logic                term;

  // >= keeps the divider sane when baud_div_i shrinks below the running count.
  always_comb begin
    div_last = (baud_div_i == '0) ? '0 : baud_div_i - DIV_SIZE'(1);
    term     = (cnt_q >= div_last);
    tick_o   = term & ~clr_i;
    cnt_d    = (clr_i | term) ? '0 : cnt_q + DIV_SIZE'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampled UART receiver with majority vote, configurable frame, parity/framing/break status.
// Frame lands in the valid/ready holding register one cycle after the last stop vote; full register drops it and sets overrun.
module uart_rx_ovs import uart_pkg::*; #(
  parameter int DIV_SIZE    = 16,
  parameter int MAX_DATA    = 9,
  parameter int OVS         = OVS_DEFAULT,
  parameter int SYNC_STAGES = 3
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                en_i,
  input  logic [DIV_SIZE-1:0] baud_div_i,
  input  logic [3:0]          data_bits_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  input  logic                stop_bits_i,
  input  logic                rx_i,
  output logic [MAX_DATA-1:0] rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                parity_err_o,
  output logic                frame_err_o,
  output logic                break_o,
  output logic                overrun_o,
  input  logic                err_clr_i
);

  localparam int OW = $clog2(OVS);
  localparam logic [OW-1:0] OVS_S0   = OW'(OVS/2 - 1);
  localparam logic [OW-1:0] OVS_S1   = OW'(OVS/2);
  localparam logic [OW-1:0] OVS_VOTE = OW'(OVS/2 + 1);
  localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rx_state_e              state_q, state_d;
  logic [OW-1:0]          ovs_q, ovs_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [MAX_DATA-1:0]    shift_q, shift_d;
  rx_cfg_t                cfg_q, cfg_d;
  logic [1:0]             samp_q, samp_d;
  logic                   par_err_q, par_err_d;
  logic                   stop_err_q, stop_err_d;
  logic                   seen_one_q, seen_one_d;
  logic [MAX_DATA-1:0]    data_q, data_d;
  logic                   valid_q, valid_d;
  logic [STAT_W-1:0]      stat_q, stat_d;
  logic                   brk_q, brk_d;
  logic                   ovr_q, ovr_d;

  logic              rx_s, tick, tick_clr;
  logic              at_vote, at_last, vote, xfer;
  logic              done, brk_det, drop;
  logic [STAT_W-1:0] new_stat;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign tick_clr = (state_q == ST_IDLE) & en_i & ~rx_s;

  uart_rx_ovs_tick #(.DIV_SIZE(DIV_SIZE)) u_tick (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (tick_clr),
    .baud_div_i (baud_div_i),
    .tick_o     (tick)
  );

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx_i};
    state_d    = state_q;
    ovs_d      = ovs_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    cfg_d      = cfg_q;
    samp_d     = samp_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    seen_one_d = seen_one_q;
    data_d     = data_q;
    valid_d    = valid_q;
    stat_d     = stat_q;
    ovr_d      = ovr_q;
    done       = 1'b0;
    brk_det    = 1'b0;
    drop       = 1'b0;
    new_stat   = '0;
    at_vote    = tick & (ovs_q == OVS_VOTE);
    at_last    = tick & (ovs_q >= OVS_LAST);
    vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    xfer       = valid_q & rx_ready_i;

    if (tick && state_q != ST_IDLE) begin
      ovs_d = at_last ? '0 : ovs_q + OW'(1);
      if (ovs_q == OVS_S0) samp_d[0] = rx_s;
      if (ovs_q == OVS_S1) samp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: if (tick_clr) begin
        state_d    = ST_START;
        ovs_d      = '0;
        bit_cnt_d  = '0;
        shift_d    = '0;
        par_err_d  = 1'b0;
        stop_err_d = 1'b0;
        seen_one_d = 1'b0;
        cfg_d      = '{nbits: clamp_bits(data_bits_i, MAX_DATA), par_en: parity_en_i,
                       par_odd: parity_odd_i, stop2: stop_bits_i};
      end
      ST_START: begin
        if (at_vote && vote) state_d = ST_IDLE;
        else if (at_last)    state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_vote) begin
          shift_d[bit_cnt_q] = vote;
          seen_one_d         = seen_one_q | vote;
        end
        if (at_last) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_d >= cfg_q.nbits) state_d = cfg_q.par_en ? ST_PARITY : ST_STOP1;
        end
      end
      ST_PARITY: begin
        if (at_vote) begin
          par_err_d  = (^shift_q) ^ vote ^ cfg_q.par_odd;
          seen_one_d = seen_one_q | vote;
        end
        if (at_last) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        new_stat[STAT_PAR] = par_err_q;
        if (at_vote) begin
          // An all-zero frame through the first stop bit is a line break, not a data frame.
          if (!vote && !seen_one_q) begin
            brk_det            = 1'b1;
            done               = 1'b1;
            new_stat[STAT_FRM] = 1'b1;
            state_d            = ST_BRK_WAIT;
          end else if (cfg_q.stop2) begin
            stop_err_d = ~vote;
          end else begin
            done               = 1'b1;
            new_stat[STAT_FRM] = ~vote;
            state_d            = ST_IDLE;
          end
        end else if (at_last && cfg_q.stop2) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        new_stat[STAT_PAR] = par_err_q;
        new_stat[STAT_FRM] = stop_err_q | ~vote;
        if (at_vote) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_BRK_WAIT: if (rx_s) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Disabling mid-frame discards the partial frame and leaves the output register alone.
    if (!en_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      done    = 1'b0;
      brk_det = 1'b0;
    end

    if (done) begin
      if (!valid_q || xfer) begin
        data_d  = shift_q;
        stat_d  = new_stat;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    if (err_clr_i) ovr_d = 1'b0;
    if (drop)      ovr_d = 1'b1;
    brk_d = brk_det;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q     <= '1;
      state_q    <= ST_IDLE;
      ovs_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      cfg_q      <= '0;
      samp_q     <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      seen_one_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      stat_q     <= '0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      ovs_q      <= ovs_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      cfg_q      <= cfg_d;
      samp_q     <= samp_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      seen_one_q <= seen_one_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      stat_q     <= stat_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign parity_err_o = stat_q[STAT_PAR];
  assign frame_err_o  = stat_q[STAT_FRM];
  assign break_o      = brk_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs at baud_div=4, OVS=16 (64 clk per bit): vector table plus corner-case sequences.
`timescale 1ns/1ps
module tb_uart_rx_ovs;

  localparam int MAXD    = 9;
  localparam int BIT_CYC = 64;

  logic            clk_i = 1'b0;
  logic            rstn_i, en_i, parity_en_i, parity_odd_i, stop_bits_i, rx_i, rx_ready_i, err_clr_i;
  logic [15:0]     baud_div_i;
  logic [3:0]      data_bits_i;
  logic [MAXD-1:0] rx_data_o;
  logic            rx_valid_o, parity_err_o, frame_err_o, break_o, overrun_o;

  uart_rx_ovs #(.DIV_SIZE(16), .MAX_DATA(MAXD), .OVS(16), .SYNC_STAGES(3)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .en_i         (en_i),
    .baud_div_i   (baud_div_i),
    .data_bits_i  (data_bits_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop_bits_i  (stop_bits_i),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .break_o      (break_o),
    .overrun_o    (overrun_o),
    .err_clr_i    (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [8:0] tx;
    logic [3:0] cfg_bits;
    int         nb;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       two;
    logic       s1;
    logic       s2;
    logic [8:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   failures = 0;
  int   brk_cnt = 0;
  int   first_valid = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Advance one cycle; a transfer about to happen at the next edge is scored here.
  task automatic cyc();
    exp_t e;
    if (rx_valid_o && rx_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: actual data=0x%0h required no frame", rx_data_o);
      end else begin
        e = sb.pop_front();
        chk("rx_data", 32'(rx_data_o), 32'(e.data));
        chk("parity_err", 32'(parity_err_o), 32'(e.perr));
        chk("frame_err", 32'(frame_err_o), 32'(e.ferr));
      end
    end
    if (break_o) brk_cnt++;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 200 && sb.size() != 0; k++) cyc();
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic send(input logic [8:0] tx, input int nb, input logic pen, input logic pbit,
                      input logic s1, input logic two, input logic s2,
                      input int pulse_at, input int en_low_at, input int rst_at);
    logic [15:0] bits;
    int n;
    int c;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int b = 0; b < nb; b++) begin bits[n] = tx[b]; n++; end
    if (pen) begin bits[n] = pbit; n++; end
    bits[n] = s1; n++;
    if (two) begin bits[n] = s2; n++; end
    first_valid = -1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < BIT_CYC; j++) begin
        c = i * BIT_CYC + j;
        rx_i = bits[i];
        if (pulse_at >= 0) rx_ready_i = (c == pulse_at);
        if (c == en_low_at) en_i = 1'b0;
        if (rst_at >= 0 && c == rst_at) rstn_i = 1'b0;
        if (rst_at >= 0 && c == rst_at + 5) rstn_i = 1'b1;
        if (first_valid < 0 && rx_valid_o) first_valid = c;
        cyc();
      end
    end
    rx_i = 1'b1;
    idle(40);
  endtask

  task automatic cfg(input logic [3:0] nb, input logic pen, input logic podd, input logic two);
    data_bits_i  = nb;
    parity_en_i  = pen;
    parity_odd_i = podd;
    stop_bits_i  = two;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0; en_i = 1'b1; baud_div_i = 16'd4; rx_i = 1'b1;
    rx_ready_i = 1'b1; err_clr_i = 1'b0;
    cfg(4'd8, 1'b0, 1'b0, 1'b0);

    //          tx      cfg   nb pen   podd  pbit  two   s1    s2    exp     perr  ferr
    vecs[0] = '{9'h0A5, 4'd8,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{9'h041, 4'd7,  7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h041, 1'b1, 1'b0};
    vecs[2] = '{9'h041, 4'd7,  7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h041, 1'b0, 1'b0};
    vecs[3] = '{9'h055, 4'd8,  8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h055, 1'b0, 1'b1};
    vecs[4] = '{9'h041, 4'd7,  7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 9'h041, 1'b0, 1'b0};
    vecs[5] = '{9'h1FF, 4'd9,  9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0};
    vecs[6] = '{9'h015, 4'd3,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h015, 1'b0, 1'b0};
    vecs[7] = '{9'h080, 4'd8,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h080, 1'b0, 1'b1};
    vecs[8] = '{9'h123, 4'd15, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h123, 1'b0, 1'b0};
    vecs[9] = '{9'h003, 4'd8,  8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h003, 1'b1, 1'b0};

    repeat (3) @(negedge clk_i);
    chk("reset_valid", 32'(rx_valid_o), 32'd0);
    chk("reset_data", 32'(rx_data_o), 32'd0);
    chk("reset_perr", 32'(parity_err_o), 32'd0);
    chk("reset_ferr", 32'(frame_err_o), 32'd0);
    chk("reset_break", 32'(break_o), 32'd0);
    chk("reset_overrun", 32'(overrun_o), 32'd0);
    rstn_i = 1'b1;
    idle(20);

    for (int i = 0; i < 10; i++) begin
      cfg(vecs[i].cfg_bits, vecs[i].pen, vecs[i].podd, vecs[i].two);
      sb.push_back('{vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr});
      send(vecs[i].tx, vecs[i].nb, vecs[i].pen, vecs[i].pbit, vecs[i].s1, vecs[i].two,
           vecs[i].s2, -1, -1, -1);
      wait_drain($sformatf("vec%0d_delivered", i));
      if (i == 0) chk("latency_window", 32'(first_valid >= 600 && first_valid <= 640), 32'd1);
    end

    // Short low glitch: rejected at the start-bit vote.
    cfg(4'd8, 1'b0, 1'b0, 1'b0);
    rx_i = 1'b0;
    idle(20);
    rx_i = 1'b1;
    idle(700);
    chk("false_start_no_valid", 32'(rx_valid_o), 32'd0);

    // Line held low for two frame times.
    brk_cnt = 0;
    sb.push_back('{9'h000, 1'b0, 1'b1});
    rx_i = 1'b0;
    idle(2 * 10 * BIT_CYC);
    chk("break_frame_delivered", 32'(sb.size()), 32'd0);
    rx_i = 1'b1;
    idle(200);
    chk("break_pulse_count", 32'(brk_cnt), 32'd1);
    chk("break_no_extra_valid", 32'(rx_valid_o), 32'd0);

    // Disable mid-data, then a clean frame.
    send(9'h077, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 200, -1);
    en_i = 1'b1;
    idle(20);
    sb.push_back('{9'h03C, 1'b0, 1'b0});
    send(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, -1);
    wait_drain("after_abort_only_3c");

    // Overrun, clear, then a transfer on the completion cycle.
    rx_ready_i = 1'b0;
    sb.push_back('{9'h011, 1'b0, 1'b0});
    send(9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, -1);
    send(9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, -1);
    chk("ovr_data_kept", 32'(rx_data_o), 32'h011);
    chk("ovr_valid", 32'(rx_valid_o), 32'd1);
    chk("ovr_set", 32'(overrun_o), 32'd1);
    err_clr_i = 1'b1;
    cyc();
    err_clr_i = 1'b0;
    cyc();
    chk("ovr_cleared", 32'(overrun_o), 32'd0);
    sb.push_back('{9'h022, 1'b0, 1'b0});
    send(9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 619, -1, -1);
    chk("same_cycle_data", 32'(rx_data_o), 32'h022);
    chk("same_cycle_valid", 32'(rx_valid_o), 32'd1);
    chk("same_cycle_no_ovr", 32'(overrun_o), 32'd0);
    chk("same_cycle_popped_11", 32'(sb.size()), 32'd1);
    rx_ready_i = 1'b1;
    wait_drain("same_cycle_drained");

    // Reset mid-frame with a held frame and overrun pending.
    rx_ready_i = 1'b0;
    send(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, -1);
    send(9'h06B, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, -1);
    chk("pre_reset_ovr", 32'(overrun_o), 32'd1);
    send(9'h0F0, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, 340);
    chk("rst_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_data", 32'(rx_data_o), 32'd0);
    chk("rst_ovr", 32'(overrun_o), 32'd0);
    chk("rst_ferr", 32'(frame_err_o), 32'd0);
    rx_ready_i = 1'b1;
    sb.push_back('{9'h0C3, 1'b0, 1'b0});
    send(9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, -1);
    wait_drain("post_reset_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
